pc_unit: RTL

- Parametrised program-counter unit that produces the instruction fetch address every cycle.
- Supersedes the fixed increment/branch counter with several additions:
  - configurable address width, step and offset width;
  - signed PC-relative branches and absolute jumps;
  - a stall hold and a synchronous clear;
  - a hardware return-address stack (RAS) for call/return.
- Sits between control/branch-resolution logic and instruction memory; its output drives the instruction memory address directly.

---
 rtl/pc_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit producing the instruction fetch address.
// Supports sequential stepping, signed PC-relative branches, absolute jumps,
// stall hold, synchronous clear and a circular hardware return-address stack.
// The fetch address is a pure register output: no combinational input-to-pc path.
module pc_unit #(
    parameter int unsigned       ADDR_W       = 64,
    parameter int unsigned       OFFSET_W     = 12,
    parameter int unsigned       OFFSET_SHIFT = 1,
    parameter int unsigned       INC          = 1,
    parameter int unsigned       RAS_DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                stall,
    input  logic [1:0]          pc_sel,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [ADDR_W-1:0]   target,
    input  logic                call,
    output logic [ADDR_W-1:0]   pc,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    localparam int unsigned       PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned       CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] INC_A    = ADDR_W'(INC);

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_RET    = 2'b11
    } sel_e;

    // Architectural state
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_top;     // index of the most recent entry
    logic [CNT_W-1:0]  r_count;   // number of valid entries, 0..RAS_DEPTH
    logic              r_empty;
    logic              r_full;
    logic              r_ovf;
    logic              r_unf;

    // Next-state values (applied only when not stalled)
    logic [ADDR_W-1:0] w_off_sext;
    logic [ADDR_W-1:0] w_ret_addr;
    logic [ADDR_W-1:0] w_branch_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [PTR_W-1:0]  w_top_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_push;
    logic              w_ovf_nxt;
    logic              w_unf_nxt;

    // Sign-extend the offset to full width before scaling so negative offsets move backwards
    assign w_off_sext  = ADDR_W'($signed(offset));
    assign w_branch_pc = r_pc + (w_off_sext << OFFSET_SHIFT);
    assign w_ret_addr  = r_pc + INC_A;

    // Next pc and RAS bookkeeping from pc_sel/call; a push onto a full stack
    // lands on the oldest slot because top+1 wraps onto it
    always_comb begin
        w_pc_nxt    = w_ret_addr;
        w_top_nxt   = r_top;
        w_count_nxt = r_count;
        w_push      = 1'b0;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        case (sel_e'(pc_sel))
            SEL_SEQ: begin
                w_pc_nxt = w_ret_addr;
            end
            SEL_BRANCH: begin
                w_pc_nxt = w_branch_pc;
                w_push   = call;
            end
            SEL_JUMP: begin
                w_pc_nxt = target;
                w_push   = call;
            end
            SEL_RET: begin
                if (r_count != '0) begin
                    w_pc_nxt    = r_ras[r_top];
                    w_top_nxt   = r_top - PTR_ONE;
                    w_count_nxt = r_count - CNT_ONE;
                end else begin
                    w_pc_nxt  = w_ret_addr;
                    w_unf_nxt = 1'b1;
                end
            end
            default: begin
                w_pc_nxt = w_ret_addr;
            end
        endcase
        if (w_push) begin
            w_top_nxt = r_top + PTR_ONE;
            if (r_count == CNT_FULL) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + CNT_ONE;
            end
        end
    end

    // State update with priority rst > clear > stall > pc_sel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_VECTOR;
            r_top   <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_ras[i] <= '0;
            end
        end else if (clear) begin
            r_pc    <= RESET_VECTOR;
            r_top   <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (!stall) begin
            r_pc    <= w_pc_nxt;
            r_top   <= w_top_nxt;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_FULL);
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
            if (w_push) begin
                r_ras[w_top_nxt] <= w_ret_addr;
            end
        end
    end

    assign pc            = r_pc;
    assign ras_empty     = r_empty;
    assign ras_full      = r_full;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule
